// File: rtl/vga_fb_renderer.sv
// Pixel stage behind the VGA timing generator: low-res framebuffer lookup,
// upscaled, with test pattern, host write port and frame counter.
module vga_fb_renderer #(
    parameter int H_DISP      = 640,
    parameter int V_DISP      = 480,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int SCALE_SHIFT = 2,
    parameter int RAM_LAT     = 1,
    parameter int FB_AW       = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_tick,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             video_in,
    input  logic [X_W-1:0]   pix_x,
    input  logic [Y_W-1:0]   pix_y,
    input  logic             pattern_en,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [FB_AW-1:0] wr_addr,
    input  logic [11:0]      wr_data,
    output logic             wr_err,
    output logic [11:0]      rgb,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             video_o,
    output logic             frame_start,
    output logic [15:0]      frame_cnt
);

    localparam int FB_W    = H_DISP >> SCALE_SHIFT;
    localparam int FB_H    = V_DISP >> SCALE_SHIFT;
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int RA_W    = $clog2(FB_SIZE);
    localparam logic [FB_AW:0] FB_LIM = (FB_AW+1)'(FB_SIZE);

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vid;
        logic       pat;
        logic [3:0] x;
        logic [3:0] y;
    } side_t;

    localparam side_t SIDE_RST = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0};

    logic [11:0]      mem [FB_SIZE];
    logic [11:0]      rd_q [RAM_LAT];
    side_t            sp [RAM_LAT];
    side_t            s0;
    side_t            last;
    logic [FB_AW-1:0] rd_addr;
    logic [FB_AW-1:0] row_c;
    logic [FB_AW-1:0] col_c;
    logic [FB_AW-1:0] addr_c;
    logic             wr_fire;
    logic             wr_oob;
    logic             vs_next;
    logic             vs_fall;

    assign row_c   = FB_AW'(pix_y >> SCALE_SHIFT);
    assign col_c   = FB_AW'(pix_x >> SCALE_SHIFT);
    assign addr_c  = row_c * FB_AW'(FB_W) + col_c;
    assign wr_ready = ~rst;
    assign wr_fire = wr_valid & wr_ready;
    assign wr_oob  = {1'b0, wr_addr} >= FB_LIM;
    assign last    = sp[RAM_LAT-1];
    assign vs_next = pix_tick ? last.vs : vsync_o;
    assign vs_fall = vsync_o & ~vs_next;

    // Read-before-write: a same-address read on a write edge sees old data.
    always_ff @(posedge clk) begin
        if (wr_fire && !wr_oob)
            mem[wr_addr[RA_W-1:0]] <= wr_data;
        if (pix_tick) begin
            rd_q[0] <= mem[rd_addr[RA_W-1:0]];
            for (int i = 1; i < RAM_LAT; i++)
                rd_q[i] <= rd_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr     <= '0;
            s0          <= SIDE_RST;
            for (int i = 0; i < RAM_LAT; i++)
                sp[i] <= SIDE_RST;
            rgb         <= '0;
            hsync_o     <= 1'b1;
            vsync_o     <= 1'b1;
            video_o     <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            wr_err      <= 1'b0;
        end else begin
            wr_err      <= wr_fire & wr_oob;
            frame_start <= vs_fall;
            if (vs_fall)
                frame_cnt <= frame_cnt + 16'd1;
            if (pix_tick) begin
                if (video_in)
                    rd_addr <= addr_c;
                s0 <= '{hsync_in, vsync_in, video_in, pattern_en,
                        pix_x[7:4], pix_y[7:4]};
                sp[0] <= s0;
                for (int i = 1; i < RAM_LAT; i++)
                    sp[i] <= sp[i-1];
                hsync_o <= last.hs;
                vsync_o <= last.vs;
                video_o <= last.vid;
                if (!last.vid)
                    rgb <= '0;
                else if (last.pat)
                    rgb <= {last.x, last.y, last.x ^ last.y};
                else
                    rgb <= rd_q[RAM_LAT-1];
            end
        end
    end

endmodule
